fifo_rd_stream: RTL
===================

# fifo_rd_stream

Read-side drain stage that sits directly downstream of `fifo_sync`. It pops words from the FIFO's registered read port and presents them on a valid/ready stream. A 3-entry output buffer absorbs the FIFO's one-cycle read latency, so the block sustains one word per cycle when the consumer is always ready. It never issues a read to an empty FIFO, so `fifo_sync` never sees a read error from this stage.

## Interface
Parameters:
- `WIDTH`, default 8: data width; must match the `WIDTH` of the upstream `fifo_sync`.

Ports:
- `clk_i`  in  1  single clock; all state updates on rising edge.
- `rst_i`  in  1  reset; synchronous, active-low.
- `fifo_empty_i`  in  1  FIFO empty flag; connects to `fifo_sync.empty_o`.
- `fifo_rdata_i`  in  WIDTH  FIFO read data; connects to `fifo_sync.rdata_o`; valid the cycle after a pop.
- `fifo_rd_en_o`  out  1  FIFO pop request; connects to `fifo_sync.rd_en_i`.
- `flush_i`  in  1  discard buffered and in-flight data.
- `m_valid_o`  out  1  stream data valid.
- `m_ready_i`  in  1  consumer ready.
- `m_data_o`  out  WIDTH  stream data.
- `buf_count_o`  out  2  current buffer occupancy, 0..3.

## Operation
- **Internal state**
  - 3-entry circular buffer `buf[0..2]`.
  - `wr_ptr` and `rd_ptr`: 2 bits each, wrapping 2→0 (never 3).
  - `count`: 0..3.
  - `inflight`: 1 bit. Set when a pop was issued in the previous cycle.
- **Pop rule (combinational)**
  - `fifo_rd_en_o = rst_i & ~flush_i & ~fifo_empty_i & (count + inflight < 3)`.
  - The rule does not depend on `m_ready_i`, so there is no ready→rd_en path.
- **Capture**
  - When `inflight`=1 and `flush_i`=0, `fifo_rdata_i` is written to `buf[wr_ptr]`.
  - `wr_ptr` then advances.
- **Stream output**
  - `m_valid_o = (count != 0) & ~flush_i`.
  - `m_data_o = buf[rd_ptr]`.
  - A transfer occurs when `m_valid_o & m_ready_i`; `rd_ptr` then advances.
- **Count update**
  - `count += capture - transfer`.
  - Capture and transfer in the same cycle leave `count` unchanged.
- **Holding rule**
  - While `m_valid_o`=1 and `m_ready_i`=0, `m_data_o` holds stable and `m_valid_o` stays high.
- **Flush (synchronous, one cycle)**
  - Next state: `count`=0, `wr_ptr`=`rd_ptr`=0, `inflight`=0.
  - A word arriving from a pop issued the prior cycle is dropped.
  - No pop is issued and no transfer occurs in the flush cycle.
- **Guarantees**
  - The credit limit `count + inflight ≤ 3` ensures the buffer never overflows.
  - Words are delivered in FIFO order with no duplication or loss, except on flush or reset.
- `buf_count_o` = `count`.

## Timing
- **Reset** (`rst_i`=0 at a rising edge)
  - State after the edge: `count`=0, `inflight`=0, pointers=0, all `buf` entries=0.
  - Outputs: `m_valid_o`=0, `m_data_o`=0, `buf_count_o`=0.
  - `fifo_rd_en_o` is held 0 for the whole cycle in which `rst_i`=0.
- **Reset mid-operation:** in-flight data is discarded, identical to flush.
- **Pop-to-valid latency: 2 cycles.**
  - Pop in cycle N.
  - `fifo_rdata_i` valid in cycle N+1 and captured at the end of N+1.
  - `m_valid_o`=1 in cycle N+2.
- **Throughput:** with `m_ready_i` held 1 and the FIFO non-empty, steady state is one pop and one transfer per cycle, with `count` settling at 1.
- **Backpressure:** with `m_ready_i`=0, at most 3 pops are issued; `fifo_rd_en_o` then stays 0 until a transfer frees a slot.
- **FIFO goes empty:** `fifo_rd_en_o` drops the same cycle `fifo_empty_i` rises; buffered words still drain.
- **Simultaneous capture and transfer at `count`=3:** impossible, because the credit rule keeps `count + inflight ≤ 3`.

## Test plan
- **Reset values:** hold `rst_i`=0 for 2 cycles with `fifo_empty_i`=0 → `fifo_rd_en_o`=0, `m_valid_o`=0, `m_data_o`=0x00, `buf_count_o`=0 throughout.
- **First-word latency:** write 0xA5 into `fifo_sync` with `m_ready_i`=1 → `fifo_rd_en_o` is 1 the first cycle `empty_o`=0, and `m_valid_o`=1 with `m_data_o`=0xA5 exactly 2 cycles later for one cycle.
- **Full throughput:** write 16 words 0x00..0x0F with `m_ready_i`=1 → 16 consecutive transfers in order once streaming starts, no gaps, and `fifo_sync.rd_error_o` never asserts.
- **Backpressure:** 16 words queued, `m_ready_i`=0 for 10 cycles → exactly 3 pops, `buf_count_o`=3, `m_data_o` stable at the first word. Then release `m_ready_i` → all 16 words received in order, and `fifo_sync.empty_o`=1 at the end.
- **Flush with in-flight pop:** `buf_count_o`=2, pop issued cycle N, `flush_i`=1 in cycle N+1 → `m_valid_o`=0 and `buf_count_o`=0 in N+2. The next delivered word is the FIFO's next unpopped word; the flushed and in-flight words are never delivered.
- **Random concurrency:** 100 random writes and random `m_ready_i` with delays of 1..10 cycles → the scoreboard matches write order exactly, and `rd_error_o`/`wr_error_o` never assert.

Source files
------------

// File: rtl/fifo_rd_stream.sv
// Read-side drain stage for fifo_sync: pops words from the FIFO's registered read
// port into a 3-entry buffer and presents them on a valid/ready stream.
module fifo_rd_stream #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             fifo_empty_i,
    input  logic [WIDTH-1:0] fifo_rdata_i,
    output logic             fifo_rd_en_o,
    input  logic             flush_i,
    output logic             m_valid_o,
    input  logic             m_ready_i,
    output logic [WIDTH-1:0] m_data_o,
    output logic [1:0]       buf_count_o
);

    logic [WIDTH-1:0] mem_q [3];
    logic [WIDTH-1:0] mem_d [3];
    logic [1:0]       wr_ptr_q, wr_ptr_d;
    logic [1:0]       rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             inflight_q, inflight_d;

    logic [2:0]       credit;
    logic             capture;
    logic             transfer;

    // Pointers cycle 0 -> 1 -> 2 -> 0 over the three entries.
    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Credit counts buffered words plus the word still on its way from the FIFO,
    // so a pop is only issued when a slot is guaranteed to be free on arrival.
    always_comb begin
        credit       = {1'b0, count_q} + {2'b00, inflight_q};
        fifo_rd_en_o = rst_i & ~flush_i & ~fifo_empty_i & (credit < 3'd3);
        capture      = inflight_q & ~flush_i;
        m_valid_o    = (count_q != 2'd0) & ~flush_i;
        transfer     = m_valid_o & m_ready_i;
        m_data_o     = mem_q[rd_ptr_q];
        buf_count_o  = count_q;
    end

    // Next-state: capture returning FIFO data, retire transferred words, flush.
    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        inflight_d = fifo_rd_en_o;

        if (capture) begin
            mem_d[wr_ptr_q] = fifo_rdata_i;
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (transfer) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({capture, transfer})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        // Flush discards buffered words and drops the word in flight.
        if (flush_i) begin
            wr_ptr_d   = 2'd0;
            rd_ptr_d   = 2'd0;
            count_d    = 2'd0;
            inflight_d = 1'b0;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= 2'd0;
            rd_ptr_q   <= 2'd0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            inflight_q <= inflight_d;
        end
    end

endmodule
